uart_cmd_wrapper: RTL and testbench
===================================

// Module: uart_cmd_wrapper
// PURPOSE
//  Host-link front end directly upstream of the command/config block.
//  Receives UART bytes on RX, assembles two consecutive bytes (high then low) into a 16-bit cmd,
//  raises cmd_rdy and holds it until clr_cmd_rdy.
//  Serialises the 8-bit resp byte onto TX on send_resp and pulses resp_sent when the stop bit is done.
//  Bit period comes from the baud_cntH/baud_cntL config registers.
// PARAMETERS
//  MIN_BAUD  16  floor on clocks/bit; any baud_cnt below it is treated as MIN_BAUD
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  RX           in   1   async serial in, idle high
//  TX           out  1   serial out, idle high
//  baud_cnt     in   16  clocks per bit = {baud_cntH, baud_cntL}; reset value of the config regs is 16'h06C8
//  cmd          out  16  assembled command, {first byte, second byte}
//  cmd_rdy      out  1   cmd valid; level
//  clr_cmd_rdy  in   1   consumer done with cmd
//  resp         in   8   byte to transmit
//  send_resp    in   1   one-cycle request to transmit resp
//  resp_sent    out  1   one-cycle pulse when a transmit completes
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): TX=1, cmd=0, cmd_rdy=0, resp_sent=0.
//   Both FSMs go to IDLE, the byte pointer goes to HIGH and both RX sync flops are set to 1.
//   Reset mid-frame aborts the frame with no partial outputs.
//  Effective period P = max(baud_cnt, MIN_BAUD). P is latched at each frame start;
//   a change to baud_cnt mid-frame does not affect the frame in progress.
//  RX path
//   - Sync: RX goes through 2 flops; falling-edge detect is done on the synced signal.
//   - RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: on a synced falling edge, load the counter with P/2 (integer divide) and go to START.
//   - START: when the counter expires, sample. If low, go to DATA with counter=P. If high, treat as a glitch and return to IDLE.
//   - DATA: sample 8 bits, LSB first, each P clocks apart, shifting into the rx shift register.
//   - STOP: after P clocks, sample. If 1, the byte is good. If 0 (framing error), discard the byte and set the byte pointer to HIGH.
//   - Good byte, pointer HIGH: store to cmd_hi and set pointer to LOW.
//   - Good byte, pointer LOW: load cmd <= {cmd_hi, byte}, set cmd_rdy=1 on the next edge, set pointer to HIGH.
//   - While cmd_rdy=1, good bytes are dropped; the pointer and cmd are unchanged. Reception itself continues.
//   - clr_cmd_rdy=1: cmd_rdy clears next edge; the pointer is forced to HIGH.
//     If clr_cmd_rdy coincides with a byte completing, the clear wins and the byte is dropped.
//  TX path
//   - TX FSM states: IDLE -> XMIT -> IDLE.
//   - IDLE with send_resp=1: latch {1'b1, resp, 1'b0} into a 10-bit shifter; TX drives the start bit from the next edge.
//   - XMIT: shift every P clocks. After 10 bit periods, TX=1, resp_sent=1 for exactly one cycle, and return to IDLE.
//   - send_resp while in XMIT is ignored; no queueing.
//   - send_resp in the same cycle as the resp_sent pulse is accepted (back-to-back bytes, as used for dumps).
//  RX and TX are fully independent; simultaneous activity is legal.
//  Counters are 16-bit; bit counters are 4-bit. No arithmetic wraps inside a frame.
// TESTING
//  1 After reset, baud_cnt=16: serialise 8'hC5 then 8'h3A on RX -> cmd=16'hC53A, cmd_rdy=1 about 320 clks after the first start edge; TX stays 1.
//  2 Hold cmd_rdy=1 and send 8'h11, 8'h22 -> cmd stays C53A.
//    Then pulse clr_cmd_rdy -> cmd_rdy=0 next clk; bytes 8'h41, 8'h00 -> cmd=16'h4100.
//  3 Send 8'h80 with stop bit 0, then 8'h12 and 8'h34 -> no cmd from the errored frame; cmd=16'h1234.
//  4 resp=8'hA5, send_resp pulse, baud_cnt=16 -> TX waveform 0,1,0,1,0,0,1,0,1,1 (16 clks each); resp_sent pulses once, 160 clks after TX start.
//    A second send_resp during XMIT is ignored.
//  5 Feed send_resp back on resp_sent with new resp values -> contiguous frames on TX with no idle gap.
//    Assert baud_cnt=4 -> bit period is 16 clks (MIN_BAUD clamp).
//  6 Assert rst mid-RX and mid-TX -> TX=1 and cmd_rdy=0 next clk; the next clean two-byte command is received correctly.
//    A 1-clk low glitch on RX produces no byte.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - UART host link: two-byte command receiver and response byte transmitter
module uart_cmd_wrapper #(
    parameter int MIN_BAUD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] baud_cnt,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);
    localparam logic [15:0] MIN_P = 16'(MIN_BAUD);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    logic [15:0] period;
    assign period = (baud_cnt < MIN_P) ? MIN_P : baud_cnt;

    rx_state_t   rx_state, rx_state_n;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt, rx_cnt_n, rx_period, rx_period_n;
    logic [3:0]  rx_bits, rx_bits_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        byte_good, frame_err;
    logic [7:0]  cmd_hi;
    logic        ptr_low;
    logic        rx_fall, rx_tick;

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = (rx_cnt == 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= 16'd0;
            rx_period <= MIN_P;
            rx_bits   <= 4'd0;
            rx_shift  <= 8'd0;
        end else begin
            rx_s1     <= RX;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_period <= rx_period_n;
            rx_bits   <= rx_bits_n;
            rx_shift  <= rx_shift_n;
        end
    end

    // The counter is loaded with N and the line is sampled N clocks later.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_period_n = rx_period;
        rx_bits_n   = rx_bits;
        rx_shift_n  = rx_shift;
        byte_good   = 1'b0;
        frame_err   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_period_n = period;
                    rx_cnt_n    = period >> 1;
                    rx_state_n  = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (!rx_s2) begin
                        rx_cnt_n   = rx_period;
                        rx_bits_n  = 4'd0;
                        rx_state_n = RX_DATA;
                    end else begin
                        rx_state_n = RX_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_cnt_n   = rx_period;
                    rx_bits_n  = rx_bits + 4'd1;
                    if (rx_bits == 4'd7) rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    byte_good  = rx_s2;
                    frame_err  = ~rx_s2;
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A clear takes priority over a byte completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd     <= 16'd0;
            cmd_hi  <= 8'd0;
            cmd_rdy <= 1'b0;
            ptr_low <= 1'b0;
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            ptr_low <= 1'b0;
        end else if (frame_err) begin
            ptr_low <= 1'b0;
        end else if (byte_good && !cmd_rdy) begin
            if (!ptr_low) begin
                cmd_hi  <= rx_shift;
                ptr_low <= 1'b1;
            end else begin
                cmd     <= {cmd_hi, rx_shift};
                cmd_rdy <= 1'b1;
                ptr_low <= 1'b0;
            end
        end
    end

    tx_state_t   tx_state, tx_state_n;
    logic [9:0]  tx_shift, tx_shift_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_period, tx_period_n;
    logic [3:0]  tx_bits, tx_bits_n;
    logic        tx_tick, tx_last, tx_start;

    assign tx_tick = (tx_cnt == 16'd1);
    assign tx_last = (tx_state == TX_XMIT) && tx_tick && (tx_bits == 4'd9);
    assign tx_start = send_resp && ((tx_state == TX_IDLE) || tx_last);
    assign TX = tx_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_shift  <= 10'h3FF;
            tx_cnt    <= 16'd0;
            tx_period <= MIN_P;
            tx_bits   <= 4'd0;
        end else begin
            tx_state  <= tx_state_n;
            tx_shift  <= tx_shift_n;
            tx_cnt    <= tx_cnt_n;
            tx_period <= tx_period_n;
            tx_bits   <= tx_bits_n;
        end
    end

    // resp_sent marks the last clock of the stop bit so a new frame can follow with no gap.
    always_comb begin
        tx_state_n  = tx_state;
        tx_shift_n  = tx_shift;
        tx_cnt_n    = tx_cnt;
        tx_period_n = tx_period;
        tx_bits_n   = tx_bits;
        resp_sent   = 1'b0;
        if (tx_state == TX_XMIT) begin
            if (tx_last) begin
                resp_sent  = 1'b1;
                tx_shift_n = 10'h3FF;
                tx_state_n = TX_IDLE;
            end else if (tx_tick) begin
                tx_shift_n = {1'b1, tx_shift[9:1]};
                tx_bits_n  = tx_bits + 4'd1;
                tx_cnt_n   = tx_period;
            end else begin
                tx_cnt_n = tx_cnt - 16'd1;
            end
        end
        if (tx_start) begin
            tx_shift_n  = {1'b1, resp, 1'b0};
            tx_cnt_n    = period;
            tx_period_n = period;
            tx_bits_n   = 4'd0;
            tx_state_n  = TX_XMIT;
        end
    end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - self-checking bench for uart_cmd_wrapper
module tb_uart_cmd_wrapper;
    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
    logic [15:0] baud_cnt, cmd;
    logic [7:0]  resp;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] cmd_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.MIN_BAUD(16)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .baud_cnt(baud_cnt),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BIT) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic wait_cmd_rdy(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (cmd_rdy === 1'b1) seen = 1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_clr;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; RX = 1'b1; send_resp = 1'b0; clr_cmd_rdy = 1'b0;
        resp = 8'h00; baud_cnt = 16'h06C8;
        repeat (3) @(negedge clk);
        rst = 1'b0; baud_cnt = 16'd16;
        @(negedge clk);
        checks++; if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", TX); end
        checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd got=%h exp=0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL reset_cmd_rdy got=%b exp=0", cmd_rdy); end
        checks++; if (resp_sent !== 1'b0) begin failures++; $display("FAIL reset_resp_sent got=%b exp=0", resp_sent); end
    endtask

    task automatic test_rx_basic;
        int lat;
        bit tx_moved;
        bit seen;
        logic [15:0] exp;
        lat = -1; tx_moved = 0;
        cmd_q.push_back(16'hC53A);
        fork
            begin rx_frame(8'hC5, 1'b1); rx_frame(8'h3A, 1'b1); end
            begin
                for (int c = 0; c < 400 && lat < 0; c++) begin
                    @(negedge clk);
                    if (TX !== 1'b1) tx_moved = 1;
                    if (cmd_rdy === 1'b1) lat = c + 1;
                end
            end
        join
        wait_cmd_rdy(50, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rx1_cmd_rdy got=%b exp=1", cmd_rdy); end
        exp = cmd_q.pop_front();
        checks++; if (cmd !== exp) begin failures++; $display("FAIL rx1_cmd got=%h exp=%h", cmd, exp); end
        checks++; if (lat < 305 || lat > 335) begin failures++; $display("FAIL rx1_latency got=%0d exp=305..335", lat); end
        checks++; if (tx_moved) begin failures++; $display("FAIL rx1_tx_idle got=active exp=idle"); end
    endtask

    task automatic test_hold_clear;
        bit seen;
        logic [15:0] exp;
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (cmd !== 16'hC53A) begin failures++; $display("FAIL hold_cmd got=%h exp=c53a", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL hold_cmd_rdy got=%b exp=1", cmd_rdy); end
        pulse_clr();
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL clr_cmd_rdy got=%b exp=0", cmd_rdy); end
        cmd_q.push_back(16'h4100);
        rx_frame(8'h41, 1'b1);
        rx_frame(8'h00, 1'b1);
        wait_cmd_rdy(50, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rx2_cmd_rdy got=%b exp=1", cmd_rdy); end
        exp = cmd_q.pop_front();
        checks++; if (cmd !== exp) begin failures++; $display("FAIL rx2_cmd got=%h exp=%h", cmd, exp); end
        pulse_clr();
    endtask

    task automatic test_framing;
        bit seen;
        logic [15:0] exp;
        rx_frame(8'h80, 1'b0);
        repeat (32) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL ferr_cmd_rdy got=%b exp=0", cmd_rdy); end
        cmd_q.push_back(16'h1234);
        rx_frame(8'h12, 1'b1);
        rx_frame(8'h34, 1'b1);
        wait_cmd_rdy(50, seen);
        checks++; if (!seen) begin failures++; $display("FAIL ferr_next_cmd_rdy got=%b exp=1", cmd_rdy); end
        exp = cmd_q.pop_front();
        checks++; if (cmd !== exp) begin failures++; $display("FAIL ferr_next_cmd got=%h exp=%h", cmd, exp); end
    endtask

    task automatic test_tx_single;
        logic [9:0] line;
        logic [7:0] exp;
        int pulses, pulse_at;
        bit idle_ok;
        pulses = 0; pulse_at = -1; idle_ok = 1; line = '1;
        baud_cnt = 16'd16; resp = 8'hA5; send_resp = 1'b1;
        tx_q.push_back(8'hA5);
        @(negedge clk);
        send_resp = 1'b0;
        checks++; if (TX !== 1'b0) begin failures++; $display("FAIL tx_start_edge got=%b exp=0", TX); end
        for (int c = 0; c < 200; c++) begin
            if (c % 16 == 8 && c / 16 < 10) line[c / 16] = TX;
            if (resp_sent === 1'b1) begin pulses++; if (pulse_at < 0) pulse_at = c; end
            if (c >= 165 && TX !== 1'b1) idle_ok = 0;
            if (c == 50) begin resp = 8'hFF; send_resp = 1'b1; end
            else if (c == 51) send_resp = 1'b0;
            @(negedge clk);
        end
        exp = tx_q.pop_front();
        checks++; if (line !== {1'b1, exp, 1'b0}) begin failures++; $display("FAIL tx_wave got=%b exp=%b", line, {1'b1, exp, 1'b0}); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL tx_resp_sent_count got=%0d exp=1", pulses); end
        checks++; if (pulse_at < 157 || pulse_at > 161) begin failures++; $display("FAIL tx_resp_sent_time got=%0d exp=157..161", pulse_at); end
        checks++; if (!idle_ok) begin failures++; $display("FAIL tx_ignore_busy_send got=activity exp=idle"); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  vals [3];
        logic [29:0] line;
        logic [7:0]  exp;
        int at [3];
        int pulses, sent;
        vals = '{8'h3C, 8'h96, 8'h5A};
        at = '{-1, -1, -1};
        pulses = 0; line = '1;
        baud_cnt = 16'd4;
        resp = vals[0]; send_resp = 1'b1; tx_q.push_back(vals[0]); sent = 1;
        @(negedge clk);
        for (int c = 0; c < 530; c++) begin
            send_resp = 1'b0;
            if (c % 16 == 8 && c / 16 < 30) line[c / 16] = TX;
            if (resp_sent === 1'b1) begin
                if (pulses < 3) at[pulses] = c;
                pulses++;
                if (sent < 3) begin
                    resp = vals[sent]; send_resp = 1'b1;
                    tx_q.push_back(vals[sent]); sent++;
                end
            end
            @(negedge clk);
        end
        send_resp = 1'b0;
        for (int f = 0; f < 3; f++) begin
            exp = tx_q.pop_front();
            checks++;
            if (line[f*10 +: 10] !== {1'b1, exp, 1'b0}) begin
                failures++; $display("FAIL b2b_frame%0d got=%b exp=%b", f, line[f*10 +: 10], {1'b1, exp, 1'b0});
            end
        end
        checks++; if (pulses != 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        checks++; if (at[1] - at[0] != 160) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=160", at[1] - at[0]); end
        checks++; if (at[2] - at[1] != 160) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=160", at[2] - at[1]); end
        baud_cnt = 16'd16;
    endtask

    task automatic test_reset_midframe;
        bit seen;
        logic [15:0] exp;
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL mid_pre_cmd_rdy got=%b exp=1", cmd_rdy); end
        resp = 8'hA5; send_resp = 1'b1; RX = 1'b0;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (15) @(negedge clk);
        RX = 1'b1;
        repeat (16) @(negedge clk);
        RX = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (TX !== 1'b0) begin failures++; $display("FAIL mid_tx_busy got=%b exp=0", TX); end
        rst = 1'b1; RX = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (TX !== 1'b1) begin failures++; $display("FAIL mid_rst_tx got=%b exp=1", TX); end
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL mid_rst_cmd_rdy got=%b exp=0", cmd_rdy); end
        checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL mid_rst_cmd got=%h exp=0000", cmd); end
        repeat (40) @(negedge clk);
        checks++; if (TX !== 1'b1) begin failures++; $display("FAIL mid_rst_tx_stays got=%b exp=1", TX); end
        checks++; if (resp_sent !== 1'b0) begin failures++; $display("FAIL mid_rst_resp_sent got=%b exp=0", resp_sent); end
        rx_frame(8'h99, 1'b1);
        RX = 1'b0;
        repeat (16) @(negedge clk);
        RX = 1'b1;
        repeat (16) @(negedge clk);
        RX = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1; RX = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        RX = 1'b0;
        @(negedge clk);
        RX = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL glitch_cmd_rdy got=%b exp=0", cmd_rdy); end
        cmd_q.push_back(16'hBEEF);
        rx_frame(8'hBE, 1'b1);
        rx_frame(8'hEF, 1'b1);
        wait_cmd_rdy(50, seen);
        checks++; if (!seen) begin failures++; $display("FAIL post_rst_cmd_rdy got=%b exp=1", cmd_rdy); end
        exp = cmd_q.pop_front();
        checks++; if (cmd !== exp) begin failures++; $display("FAIL post_rst_cmd got=%h exp=%h", cmd, exp); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rx_basic();
        test_hold_clear();
        test_framing();
        test_tx_single();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
